// File: rtl/par8_cmd_ctrl.sv
// par8_cmd_ctrl: byte-level command sequencer.
// Frames strobed bytes from the parallel-bus receiver as opcode, length and
// payload. Valid payload goes out as a marked stream. A one-byte acknowledge
// goes back through the transmitter handshake. Unknown-opcode, timeout and
// overrun conditions are reported as one-cycle pulses.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   rxd_data/_ready   receiver byte and its one-cycle strobe
//   cmd, cmd_len      latched opcode / payload length of the current frame
//   cmd_start         pulse: cmd/cmd_len newly valid (good opcode only)
//   pay_data/_valid   payload byte stream; pay_last marks the final byte
//   pay_last
//   tx_data/_valid    acknowledge byte (opcode, or 0xEE for a bad frame)
//   tx_ready          transmitter accepts on tx_valid & tx_ready
//   busy              high whenever a frame or acknowledge is in progress
//   err_unknown       pulse: opcode outside 0x01-0x0F
//   err_timeout       pulse: frame aborted after the inter-byte timeout
//   err_overrun       pulse: byte dropped while the acknowledge is pending
module par8_cmd_ctrl #(
    parameter int unsigned TIMEOUT_W = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rxd_data,
    input  logic       rxd_data_ready,
    output logic [7:0] cmd,
    output logic [7:0] cmd_len,
    output logic       cmd_start,
    output logic [7:0] pay_data,
    output logic       pay_valid,
    output logic       pay_last,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       err_unknown,
    output logic       err_timeout,
    output logic       err_overrun
);

    localparam int unsigned BYTE_W  = 8;
    localparam logic [BYTE_W-1:0] OP_MIN  = BYTE_W'(8'h01);
    localparam logic [BYTE_W-1:0] OP_MAX  = BYTE_W'(8'h0F);
    localparam logic [BYTE_W-1:0] NAK_BYTE = BYTE_W'(8'hEE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEN,
        ST_PAYLOAD,
        ST_ACK
    } state_t;

    state_t              state, state_d;
    logic                bad, bad_d;
    logic [BYTE_W-1:0]   rem, rem_d;
    logic [TIMEOUT_W-1:0] tout, tout_d;

    logic [BYTE_W-1:0]   cmd_d, cmd_len_d, pay_data_d, tx_data_d;
    logic                cmd_start_d, pay_valid_d, pay_last_d;
    logic                tx_valid_d, busy_d;
    logic                err_unknown_d, err_timeout_d, err_overrun_d;

    // Next-state and next-output logic; every registered output is recomputed here.
    always_comb begin
        state_d       = state;
        bad_d         = bad;
        rem_d         = rem;
        tout_d        = tout;
        cmd_d         = cmd;
        cmd_len_d     = cmd_len;
        cmd_start_d   = 1'b0;
        pay_data_d    = '0;
        pay_valid_d   = 1'b0;
        pay_last_d    = 1'b0;
        err_unknown_d = 1'b0;
        err_timeout_d = 1'b0;
        err_overrun_d = 1'b0;

        // Inter-byte timer runs only while a frame is partially received.
        if (rxd_data_ready || state == ST_IDLE || state == ST_ACK) begin
            tout_d = '0;
        end else begin
            tout_d = tout + TIMEOUT_W'(1);
        end

        unique case (state)
            ST_IDLE: begin
                if (rxd_data_ready) begin
                    cmd_d         = rxd_data;
                    bad_d         = (rxd_data < OP_MIN) || (rxd_data > OP_MAX);
                    err_unknown_d = bad_d;
                    state_d       = ST_LEN;
                end
            end
            ST_LEN: begin
                if (rxd_data_ready) begin
                    cmd_len_d   = rxd_data;
                    rem_d       = rxd_data;
                    cmd_start_d = !bad;
                    state_d     = (rxd_data != '0) ? ST_PAYLOAD : ST_ACK;
                end else if (&tout) begin
                    err_timeout_d = 1'b1;
                    tout_d        = '0;
                    state_d       = ST_IDLE;
                end
            end
            ST_PAYLOAD: begin
                if (rxd_data_ready) begin
                    rem_d = rem - BYTE_W'(1);
                    // A bad frame's payload is swallowed so framing stays aligned.
                    if (!bad) begin
                        pay_valid_d = 1'b1;
                        pay_data_d  = rxd_data;
                        pay_last_d  = (rem == BYTE_W'(1));
                    end
                    if (rem == BYTE_W'(1)) begin
                        state_d = ST_ACK;
                    end
                end else if (&tout) begin
                    err_timeout_d = 1'b1;
                    tout_d        = '0;
                    state_d       = ST_IDLE;
                end
            end
            ST_ACK: begin
                err_overrun_d = rxd_data_ready;
                if (tx_valid && tx_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Acknowledge and busy are derived from where the frame will be next cycle.
        tx_valid_d = (state_d == ST_ACK);
        tx_data_d  = tx_valid_d ? (bad_d ? NAK_BYTE : cmd_d) : '0;
        busy_d     = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            bad         <= 1'b0;
            rem         <= '0;
            tout        <= '0;
            cmd         <= '0;
            cmd_len     <= '0;
            cmd_start   <= 1'b0;
            pay_data    <= '0;
            pay_valid   <= 1'b0;
            pay_last    <= 1'b0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            busy        <= 1'b0;
            err_unknown <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            state       <= state_d;
            bad         <= bad_d;
            rem         <= rem_d;
            tout        <= tout_d;
            cmd         <= cmd_d;
            cmd_len     <= cmd_len_d;
            cmd_start   <= cmd_start_d;
            pay_data    <= pay_data_d;
            pay_valid   <= pay_valid_d;
            pay_last    <= pay_last_d;
            tx_data     <= tx_data_d;
            tx_valid    <= tx_valid_d;
            busy        <= busy_d;
            err_unknown <= err_unknown_d;
            err_timeout <= err_timeout_d;
            err_overrun <= err_overrun_d;
        end
    end

endmodule

// File: tb/tb_par8_cmd_ctrl.sv
// Testbench for par8_cmd_ctrl: directed frames plus random byte traffic,
// compared every cycle against a frame-level reference model.
module tb_par8_cmd_ctrl;

    localparam int unsigned TW       = 4;
    localparam int          TOUT_MAX = (1 << TW) - 1;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rxd_data;
    logic       rxd_data_ready;
    logic [7:0] cmd, cmd_len, pay_data, tx_data;
    logic       cmd_start, pay_valid, pay_last, tx_valid, tx_ready, busy;
    logic       err_unknown, err_timeout, err_overrun;

    par8_cmd_ctrl #(.TIMEOUT_W(TW)) dut (
        .clk(clk), .reset(reset),
        .rxd_data(rxd_data), .rxd_data_ready(rxd_data_ready),
        .cmd(cmd), .cmd_len(cmd_len), .cmd_start(cmd_start),
        .pay_data(pay_data), .pay_valid(pay_valid), .pay_last(pay_last),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .err_unknown(err_unknown), .err_timeout(err_timeout),
        .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    bit rdy    = 1'b1;

    // Reference model: the bytes of the frame seen so far, plus acknowledge state.
    logic [7:0] frame_q[$];
    bit         m_ack, m_bad;
    int         m_idle;
    logic [7:0] e_cmd, e_len, e_pd;
    bit         e_start, e_pv, e_pl, e_eu, e_et, e_eo;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        frame_q.delete();
        m_ack = 0; m_bad = 0; m_idle = 0;
        e_cmd = 0; e_len = 0; e_pd = 0;
        e_start = 0; e_pv = 0; e_pl = 0; e_eu = 0; e_et = 0; e_eo = 0;
    endtask

    task automatic model_step(input bit s, input logic [7:0] b, input bit r);
        int n, len;
        e_start = 0; e_pv = 0; e_pl = 0; e_pd = 0; e_eu = 0; e_et = 0; e_eo = 0;
        if (m_ack) begin
            m_idle = 0;
            if (s) e_eo = 1;
            if (r) begin
                m_ack = 0;
                frame_q.delete();
            end
        end else if (frame_q.size() == 0) begin
            m_idle = 0;
            if (s) begin
                frame_q.push_back(b);
                e_cmd = b;
                m_bad = !(b >= 8'h01 && b <= 8'h0F);
                e_eu  = m_bad;
            end
        end else if (s) begin
            m_idle = 0;
            frame_q.push_back(b);
            n = frame_q.size();
            if (n == 2) begin
                e_len   = b;
                e_start = !m_bad;
                if (b == 0) m_ack = 1;
            end else begin
                len = int'(frame_q[1]);
                if (!m_bad) begin
                    e_pv = 1;
                    e_pd = b;
                    e_pl = (n == len + 2);
                end
                if (n == len + 2) m_ack = 1;
            end
        end else if (m_idle == TOUT_MAX) begin
            e_et = 1;
            m_idle = 0;
            frame_q.delete();
        end else begin
            m_idle++;
        end
    endtask

    task automatic compare_all();
        logic [7:0] e_tx;
        e_tx = m_ack ? (m_bad ? 8'hEE : e_cmd) : 8'h00;
        chk("cmd",         16'(cmd),         16'(e_cmd));
        chk("cmd_len",     16'(cmd_len),     16'(e_len));
        chk("cmd_start",   16'(cmd_start),   16'(e_start));
        chk("pay_valid",   16'(pay_valid),   16'(e_pv));
        chk("pay_data",    16'(pay_data),    16'(e_pd));
        chk("pay_last",    16'(pay_last),    16'(e_pl));
        chk("tx_valid",    16'(tx_valid),    16'(m_ack));
        chk("tx_data",     16'(tx_data),     16'(e_tx));
        chk("busy",        16'(busy),        16'(m_ack || frame_q.size() != 0));
        chk("err_unknown", 16'(err_unknown), 16'(e_eu));
        chk("err_timeout", 16'(err_timeout), 16'(e_et));
        chk("err_overrun", 16'(err_overrun), 16'(e_eo));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_outs"}, {cmd, cmd_len}, 16'h0000);
        chk({tag, "_data"}, {pay_data, tx_data}, 16'h0000);
        chk({tag, "_flags"},
            16'({cmd_start, pay_valid, pay_last, tx_valid, busy,
                 err_unknown, err_timeout, err_overrun}), 16'h0000);
    endtask

    // One clock cycle: drive inputs, advance, update model, compare.
    task automatic cycle(input bit s, input logic [7:0] b);
        rxd_data_ready = s;
        rxd_data       = s ? b : 8'($urandom);
        tx_ready       = rdy;
        @(posedge clk);
        model_step(s, b, rdy);
        #1;
        compare_all();
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        cycle(1'b1, b);
        for (int i = 0; i < gap; i++) cycle(1'b0, 8'h00);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
    endtask

    task automatic pulse_reset(input string tag);
        rxd_data_ready = 1'b0;
        #2 reset = 1'b1;
        #1 check_zero(tag);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rxd_data = 0; rxd_data_ready = 0; tx_ready = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // Normal frame, one strobe per 4 cycles.
        rdy = 1;
        send(8'h03, 3); send(8'h02, 3); send(8'hAA, 3); send(8'h55, 3);
        idle(3);

        // Zero-length frame with acknowledge held off for 10 cycles.
        rdy = 0;
        send(8'h01, 0); send(8'h00, 0);
        idle(10);
        rdy = 1;
        idle(3);

        // Unknown opcode.
        send(8'h80, 1); send(8'h01, 1); send(8'h12, 1);
        idle(3);

        // Timeout mid-payload, then a clean frame.
        send(8'h02, 0); send(8'h03, 0); send(8'h11, 0);
        idle(TOUT_MAX + 4);
        send(8'h01, 0); send(8'h00, 0);
        idle(3);

        // Overrun during a pending acknowledge.
        rdy = 0;
        send(8'h04, 0); send(8'h00, 2);
        send(8'h77, 2);
        rdy = 1;
        idle(3);

        // Back-to-back strobes, every cycle.
        send(8'h0F, 0); send(8'h03, 0); send(8'h01, 0); send(8'h02, 0); send(8'h03, 0);
        idle(3);

        // Reset in the middle of a 4-byte payload.
        send(8'h06, 0); send(8'h04, 0); send(8'h10, 0); send(8'h20, 0);
        pulse_reset("midreset");
        send(8'h05, 1); send(8'h01, 1); send(8'h9C, 1);
        idle(4);

        // Random traffic, with idle stretches to provoke timeouts.
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] b;
            rdy = ($urandom_range(0, 3) != 0);
            b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
            if (i % 250 == 249) idle(TOUT_MAX + 3);
            else cycle(($urandom_range(0, 1) == 1), b);
        end
        pulse_reset("endreset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
